// File: rtl/rc4_cipher_mm.sv
// RC4 stream-cipher engine behind a CPU memory-mapped slave port.
// The S-box lives in flops; the key schedule runs one iteration per cycle,
// then 32-bit words stream from an input FIFO, through keystream XOR,
// into an output FIFO.
module rc4_cipher_mm #(
  parameter int ADDR_W        = 12,
  parameter int KEY_MAX_BYTES = 16,
  parameter int IN_DEPTH      = 4,
  parameter int OUT_DEPTH     = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic              Cpu_Sel,
  input  logic              Cpu_Read,
  input  logic              Cpu_Writ,
  input  logic [31:0]       Cpu_DataWr,
  output logic [31:0]       Cpu_DataRd
);

  localparam int KEY_WORDS = KEY_MAX_BYTES / 4;
  localparam int KIDX_W    = $clog2(KEY_MAX_BYTES);
  localparam int IN_AW     = $clog2(IN_DEPTH);
  localparam int IN_CW     = IN_AW + 1;
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int OUT_CW    = OUT_AW + 1;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_KEYLEN = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_DIN    = ADDR_W'(32);
  localparam logic [ADDR_W-1:0] A_DOUT   = ADDR_W'(33);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSA, ST_LOAD, ST_GEN, ST_PUSH
  } state_t;

  state_t r_state, w_next;

  logic [7:0]          r_sbox [256];
  logic [7:0]          r_i, r_j;
  logic [KIDX_W-1:0]   r_kidx;
  logic [8:0]          r_keylen;
  logic [7:0]          r_key [KEY_MAX_BYTES];
  logic                r_ready;
  logic                r_ovf, r_unf, r_nre;
  logic [31:0]         r_in_mem [IN_DEPTH];
  logic [IN_AW-1:0]    r_in_wp, r_in_rp;
  logic [IN_CW-1:0]    r_in_cnt;
  logic [31:0]         r_out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0]   r_out_wp, r_out_rp;
  logic [OUT_CW-1:0]   r_out_cnt;
  logic [31:0]         r_word, r_res;
  logic [1:0]          r_byte;
  logic [31:0]         r_rdata;

  logic w_wr, w_rd, w_ctrl_wr, w_start, w_clr, w_busy, w_keylen_ok;
  logic w_start_ok, w_din, w_dout, w_din_ok, w_out_pop;
  logic w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic w_ovf_set, w_unf_set, w_nre_set;
  logic w_in_pop, w_out_push, w_swap;
  logic [KEY_WORDS-1:0] w_key_match;
  logic [31:0] w_key_rdata, w_status, w_rdata;
  logic [7:0]  w_ia, w_sa, w_kb, w_jb, w_sb, w_t, w_ks;

  assign w_wr        = Cpu_Sel & Cpu_Writ;
  assign w_rd        = Cpu_Sel & Cpu_Read;
  assign w_ctrl_wr   = w_wr && (Cpu_Addr == A_CTRL);
  assign w_start     = w_ctrl_wr & Cpu_DataWr[0];
  assign w_clr       = w_ctrl_wr & Cpu_DataWr[2];
  assign w_din       = w_wr && (Cpu_Addr == A_DIN);
  assign w_dout      = w_rd && (Cpu_Addr == A_DOUT);
  assign w_busy      = (r_state == ST_INIT) || (r_state == ST_KSA);
  assign w_keylen_ok = (r_keylen != 9'd0) && (r_keylen <= 9'(KEY_MAX_BYTES));
  assign w_in_full   = (r_in_cnt == IN_CW'(IN_DEPTH));
  assign w_in_empty  = (r_in_cnt == '0);
  assign w_out_full  = (r_out_cnt == OUT_CW'(OUT_DEPTH));
  assign w_out_empty = (r_out_cnt == '0);
  assign w_start_ok  = w_start && (r_state == ST_IDLE) && w_keylen_ok;
  assign w_din_ok    = w_din && !w_in_full && r_ready;
  assign w_out_pop   = w_dout && !w_out_empty;
  assign w_ovf_set   = w_din && w_in_full;
  assign w_unf_set   = w_dout && w_out_empty;
  assign w_nre_set   = (w_start && !w_start_ok) || (w_din && !w_in_full && !r_ready);

  // Shared swap datapath: KSA uses index i with key byte, PRGA uses i+1 without.
  assign w_ia   = (r_state == ST_GEN) ? (r_i + 8'd1) : r_i;
  assign w_sa   = r_sbox[w_ia];
  assign w_kb   = (r_state == ST_KSA) ? r_key[r_kidx] : 8'd0;
  assign w_jb   = r_j + w_sa + w_kb;
  assign w_sb   = r_sbox[w_jb];
  assign w_t    = w_sa + w_sb;
  // Keystream byte read from the post-swap S-box, forwarding the two swapped entries.
  assign w_ks   = (w_t == w_ia) ? w_sb : ((w_t == w_jb) ? w_sa : r_sbox[w_t]);
  assign w_swap = (r_state == ST_KSA) || (r_state == ST_GEN);

  assign w_status = {8'h00, 8'(r_in_cnt), 8'(r_out_cnt), 1'b0, r_nre, r_unf, r_ovf,
                     w_out_empty, w_in_full, r_ready, w_busy};

  // Key-word address decode and read-back mux; the DATA ports take priority on overlap.
  always_comb begin
    w_key_match = '0;
    w_key_rdata = '0;
    for (int unsigned w = 0; w < KEY_WORDS; w++) begin
      if ((Cpu_Addr == ADDR_W'(16 + w)) && (Cpu_Addr != A_DIN) && (Cpu_Addr != A_DOUT)) begin
        w_key_match[w] = 1'b1;
        w_key_rdata    = {r_key[4*w+3], r_key[4*w+2], r_key[4*w+1], r_key[4*w]};
      end
    end
  end

  // Read data select for the registered read port.
  always_comb begin
    w_rdata = '0;
    if (Cpu_Addr == A_STATUS)      w_rdata = w_status;
    else if (Cpu_Addr == A_KEYLEN) w_rdata = {23'd0, r_keylen};
    else if (Cpu_Addr == A_DOUT)   w_rdata = w_out_empty ? 32'd0 : r_out_mem[r_out_rp];
    else if (|w_key_match)         w_rdata = w_key_rdata;
  end

  // Engine state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Engine next-state and FIFO handshakes.
  // A word is only started when the output FIFO has room, so full input plus
  // full output is the total buffering; the IDLE test also sees a DATA_IN write
  // landing this cycle so LOAD starts on the write edge itself.
  always_comb begin
    w_next     = r_state;
    w_in_pop   = 1'b0;
    w_out_push = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_next = ST_INIT;
        else if (r_ready && (!w_in_empty || w_din_ok) && !w_out_full) w_next = ST_LOAD;
      end
      ST_INIT: w_next = ST_KSA;
      ST_KSA:  if (r_i == 8'hFF) w_next = ST_IDLE;
      ST_LOAD: begin
        w_in_pop = 1'b1;
        w_next   = ST_GEN;
      end
      ST_GEN:  if (r_byte == 2'd3) w_next = ST_PUSH;
      ST_PUSH: begin
        if (!w_out_full) begin
          w_out_push = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // S-box: identity fill in INIT, one swap per KSA/GEN cycle.
  always_ff @(posedge Clk) begin
    for (int unsigned k = 0; k < 256; k++) begin
      if (r_state == ST_INIT) r_sbox[k] <= 8'(k);
      else if (w_swap) begin
        if (8'(k) == w_jb)      r_sbox[k] <= w_sa;
        else if (8'(k) == w_ia) r_sbox[k] <= w_sb;
      end
    end
  end

  // FIFO storage arrays.
  always_ff @(posedge Clk) begin
    if (w_din_ok)   r_in_mem[r_in_wp]   <= Cpu_DataWr;
    if (w_out_push) r_out_mem[r_out_wp] <= r_res;
  end

  // Control registers, counters, FIFO pointers, datapath and error flags.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_i       <= '0;
      r_j       <= '0;
      r_kidx    <= '0;
      r_keylen  <= '0;
      for (int unsigned b = 0; b < KEY_MAX_BYTES; b++) r_key[b] <= '0;
      r_ready   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_nre     <= 1'b0;
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_word    <= '0;
      r_res     <= '0;
      r_byte    <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_wr && !w_busy && (Cpu_Addr == A_KEYLEN)) r_keylen <= Cpu_DataWr[8:0];
      for (int unsigned w = 0; w < KEY_WORDS; w++) begin
        if (w_wr && !w_busy && w_key_match[w]) begin
          for (int unsigned b = 0; b < 4; b++) r_key[4*w+b] <= Cpu_DataWr[8*b +: 8];
        end
      end

      case (r_state)
        ST_INIT: begin
          r_i    <= '0;
          r_j    <= '0;
          r_kidx <= '0;
        end
        ST_KSA: begin
          r_i    <= r_i + 8'd1;
          r_j    <= (r_i == 8'hFF) ? 8'd0 : w_jb;
          r_kidx <= (9'(r_kidx) == (r_keylen - 9'd1)) ? '0 : (r_kidx + KIDX_W'(1));
        end
        ST_LOAD: begin
          r_word <= r_in_mem[r_in_rp];
          r_byte <= '0;
        end
        ST_GEN: begin
          r_i    <= w_ia;
          r_j    <= w_jb;
          r_word <= {8'h00, r_word[31:8]};
          r_res  <= {r_word[7:0] ^ w_ks, r_res[31:8]};
          r_byte <= r_byte + 2'd1;
        end
        default: ;
      endcase

      if (w_start_ok) r_ready <= 1'b0;
      else if ((r_state == ST_KSA) && (r_i == 8'hFF)) r_ready <= 1'b1;

      if (w_start_ok) begin
        r_in_wp   <= '0;
        r_in_rp   <= '0;
        r_in_cnt  <= '0;
        r_out_wp  <= '0;
        r_out_rp  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_din_ok) r_in_wp <= r_in_wp + IN_AW'(1);
        if (w_in_pop) r_in_rp <= r_in_rp + IN_AW'(1);
        case ({w_din_ok, w_in_pop})
          2'b10:   r_in_cnt <= r_in_cnt + IN_CW'(1);
          2'b01:   r_in_cnt <= r_in_cnt - IN_CW'(1);
          default: ;
        endcase
        if (w_out_push) r_out_wp <= r_out_wp + OUT_AW'(1);
        if (w_out_pop)  r_out_rp <= r_out_rp + OUT_AW'(1);
        case ({w_out_push, w_out_pop})
          2'b10:   r_out_cnt <= r_out_cnt + OUT_CW'(1);
          2'b01:   r_out_cnt <= r_out_cnt - OUT_CW'(1);
          default: ;
        endcase
      end

      r_ovf <= (r_ovf & ~w_clr) | w_ovf_set;
      r_unf <= (r_unf & ~w_clr) | w_unf_set;
      r_nre <= (r_nre & ~w_clr) | w_nre_set;

      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign Cpu_DataRd = r_rdata;

endmodule
